// File: rtl/ula_pkg.sv
// Shared constants for the ALU control sequencer: select codes, ula_op
// encodings, funct7 patterns and the sequencer state type.
package ula_pkg;

  // Width of the raw select code produced by the decoder
  localparam int CODE_W = 5;

  // Single-cycle ALU select codes
  localparam logic [4:0] ULA_ADD    = 5'd0;
  localparam logic [4:0] ULA_SUB    = 5'd1;
  localparam logic [4:0] ULA_SLL    = 5'd2;
  localparam logic [4:0] ULA_SLT    = 5'd3;
  localparam logic [4:0] ULA_SLTU   = 5'd4;
  localparam logic [4:0] ULA_XOR    = 5'd5;
  localparam logic [4:0] ULA_SRL    = 5'd6;
  localparam logic [4:0] ULA_SRA    = 5'd7;
  localparam logic [4:0] ULA_OR     = 5'd8;
  localparam logic [4:0] ULA_AND    = 5'd9;

  // Multi-cycle mul/div select codes (MUL + funct3)
  localparam logic [4:0] ULA_MUL    = 5'd16;
  localparam logic [4:0] ULA_MULH   = 5'd17;
  localparam logic [4:0] ULA_MULHSU = 5'd18;
  localparam logic [4:0] ULA_MULHU  = 5'd19;
  localparam logic [4:0] ULA_DIV    = 5'd20;
  localparam logic [4:0] ULA_DIVU   = 5'd21;
  localparam logic [4:0] ULA_REM    = 5'd22;
  localparam logic [4:0] ULA_REMU   = 5'd23;

  // ula_op encodings from the main control unit
  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_ITYPE  = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  // funct7 patterns
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  // funct3 -> base ALU op, with 101 meaning the logical right shift
  function automatic logic [4:0] base_code(input logic [2:0] f3);
    logic [4:0] c;
    c = ULA_ADD;
    case (f3)
      3'b000:  c = ULA_ADD;
      3'b001:  c = ULA_SLL;
      3'b010:  c = ULA_SLT;
      3'b011:  c = ULA_SLTU;
      3'b100:  c = ULA_XOR;
      3'b101:  c = ULA_SRL;
      3'b110:  c = ULA_OR;
      default: c = ULA_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ula_decode.sv
// Combinational decoder: {funct7,funct3} and ula_op -> select code plus
// flags telling the sequencer whether the op is multi-cycle, a divide,
// or an undecodable encoding.
module ula_decode
  import ula_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [9:0]        i_inst,
  input  logic [1:0]        i_ula_op,
  output logic [CODE_W-1:0] o_code,
  output logic              o_is_multi,
  output logic              o_is_div,
  output logic              o_illegal
);

  logic [6:0] w_f7;
  logic [2:0] w_f3;

  assign w_f7 = i_inst[9:3];
  assign w_f3 = i_inst[2:0];

  // Decode table; code is don't-care whenever illegal is raised
  always_comb begin
    o_code     = ULA_ADD;
    o_is_multi = 1'b0;
    o_is_div   = 1'b0;
    o_illegal  = 1'b0;
    case (i_ula_op)
      OP_ADD: begin
        o_code = ULA_ADD;
      end
      OP_ITYPE: begin
        o_code = base_code(w_f3);
        if (w_f3 == 3'b001) begin
          o_illegal = (w_f7 != F7_BASE);
        end else if (w_f3 == 3'b101) begin
          // Shift immediates carry the arithmetic flag in funct7[5]
          o_code    = i_inst[8] ? ULA_SRA : ULA_SRL;
          o_illegal = !((w_f7 == F7_BASE) || (w_f7 == F7_ALT));
        end
      end
      OP_RTYPE: begin
        if (w_f7 == F7_BASE) begin
          o_code = base_code(w_f3);
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'b000) begin
            o_code = ULA_SUB;
          end else if (w_f3 == 3'b101) begin
            o_code = ULA_SRA;
          end else begin
            o_illegal = 1'b1;
          end
        end else if (w_f7 == F7_MULDIV) begin
          o_code = ULA_MUL + {2'b00, w_f3};
          if (ENABLE_M != 0) begin
            o_is_multi = 1'b1;
            o_is_div   = w_f3[2];
          end else begin
            o_illegal = 1'b1;
          end
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: begin
        // Branch compares: equality via SUB, signed/unsigned via SLT/SLTU
        case (w_f3[2:1])
          2'b00:   o_code = ULA_SUB;
          2'b10:   o_code = ULA_SLT;
          2'b11:   o_code = ULA_SLTU;
          default: o_illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ula_control_seq.sv
// Registered ALU control with a busy/done sequencer for multi-cycle
// mul/div ops. Single-cycle ops produce a sel_valid pulse one cycle after
// acceptance; mul/div ops hold busy for exactly MUL_CYCLES/DIV_CYCLES
// cycles and pulse done on the last one.
module ula_control_seq
  import ula_pkg::*;
#(
  parameter int SEL_W      = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int ENABLE_M   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [9:0]       inst,
  input  logic [1:0]       ula_op,
  input  logic             flush,
  output logic [SEL_W-1:0] ula_select,
  output logic             sel_valid,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_load;
  logic [SEL_W-1:0] r_sel, w_sel_next, w_code_ext;
  logic             r_sel_valid, w_sel_valid_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_illegal, w_illegal_next;

  logic [CODE_W-1:0] w_code;
  logic              w_is_multi;
  logic              w_is_div;
  logic              w_dec_illegal;
  logic              w_accept;

  ula_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .i_inst     (inst),
    .i_ula_op   (ula_op),
    .o_code     (w_code),
    .o_is_multi (w_is_multi),
    .o_is_div   (w_is_div),
    .o_illegal  (w_dec_illegal)
  );

  assign w_code_ext = SEL_W'(w_code);
  assign w_cnt_load = w_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
  assign w_accept   = valid_in & ~r_busy & ~flush;

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_sel_next       = r_sel;
    w_sel_valid_next = 1'b0;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_illegal_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy_next = 1'b0;
        if (w_accept) begin
          if (w_dec_illegal) begin
            w_illegal_next = 1'b1;
          end else if (w_is_multi) begin
            w_sel_next   = w_code_ext;
            w_busy_next  = 1'b1;
            w_cnt_next   = w_cnt_load;
            // A one-cycle multi op is done in its first busy cycle
            w_done_next  = (w_cnt_load == '0);
            w_state_next = ST_MULTI;
          end else begin
            w_sel_next       = w_code_ext;
            w_sel_valid_next = 1'b1;
          end
        end
      end
      ST_MULTI: begin
        w_busy_next = 1'b1;
        if (flush) begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
          w_cnt_next   = '0;
        end else if (r_cnt == '0) begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
        end else begin
          w_cnt_next  = r_cnt - CNT_W'(1);
          // done is registered, so raise it when the counter is about to hit 0
          w_done_next = (r_cnt == CNT_W'(1));
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_sel       <= w_sel_next;
      r_sel_valid <= w_sel_valid_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_illegal   <= w_illegal_next;
    end
  end

  assign ready_out  = ~r_busy;
  assign ula_select = r_sel;
  assign sel_valid  = r_sel_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_ula_control_seq.sv
// Directed bench for ula_control_seq. Expected pulses (kind, select code,
// due cycle) are queued when stimulus is driven and checked by a monitor
// when the DUT raises sel_valid/illegal/done.
module tb_ula_control_seq;

  localparam int K_SEL  = 0;
  localparam int K_ILL  = 1;
  localparam int K_DONE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic       valid_nom = 1'b0;
  logic       flush = 1'b0;
  logic [9:0] inst = '0;
  logic [1:0] ula_op = '0;

  logic       ready_out, sel_valid, busy, done, illegal;
  logic [4:0] ula_select;
  logic       nom_ready, nom_sel_valid, nom_busy, nom_done, nom_illegal;
  logic [4:0] nom_select;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_sel = 0;

  typedef struct {
    int kind;
    int code;
    int due;
  } exp_t;
  exp_t sb[$];

  logic [9:0] sweep_inst [10];

  ula_control_seq #(
    .SEL_W(5), .MUL_CYCLES(4), .DIV_CYCLES(32), .ENABLE_M(1)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .inst(inst), .ula_op(ula_op), .flush(flush), .ula_select(ula_select),
    .sel_valid(sel_valid), .busy(busy), .done(done), .illegal(illegal)
  );

  ula_control_seq #(
    .SEL_W(5), .MUL_CYCLES(4), .DIV_CYCLES(32), .ENABLE_M(0)
  ) dut_nom (
    .clk(clk), .rst(rst), .valid_in(valid_nom), .ready_out(nom_ready),
    .inst(inst), .ula_op(ula_op), .flush(flush), .ula_select(nom_select),
    .sel_valid(nom_sel_valid), .busy(nom_busy), .done(nom_done), .illegal(nom_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int code, input int lat);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.due  = cyc + lat;
    sb.push_back(e);
  endtask

  // Issue one op for one cycle; code < 0 means the encoding must be illegal
  task automatic single(input logic [1:0] op, input logic [9:0] in, input int code);
    ula_op   = op;
    inst     = in;
    valid_in = 1'b1;
    if (code < 0) begin
      push(K_ILL, last_sel, 1);
    end else begin
      push(K_SEL, code, 1);
      last_sel = code;
    end
    step();
    valid_in = 1'b0;
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue
  always @(negedge clk) begin : monitor
    int   npulse;
    int   kind_obs;
    exp_t e;
    npulse = int'(sel_valid) + int'(done) + int'(illegal);
    if (npulse != 0) begin
      chk("pulse_exclusive", npulse, 1);
      kind_obs = sel_valid ? K_SEL : (illegal ? K_ILL : K_DONE);
      if (sb.size() == 0) begin
        chk("unexpected_pulse_kind", kind_obs + 100, 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", kind_obs, e.kind);
        chk("pulse_select", ula_select, e.code);
        chk("pulse_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    sweep_inst[0] = 10'b0000000_000; // ADD
    sweep_inst[1] = 10'b0100000_000; // SUB
    sweep_inst[2] = 10'b0000000_001; // SLL
    sweep_inst[3] = 10'b0000000_010; // SLT
    sweep_inst[4] = 10'b0000000_011; // SLTU
    sweep_inst[5] = 10'b0000000_100; // XOR
    sweep_inst[6] = 10'b0000000_101; // SRL
    sweep_inst[7] = 10'b0100000_101; // SRA
    sweep_inst[8] = 10'b0000000_110; // OR
    sweep_inst[9] = 10'b0000000_111; // AND

    // Reset values
    repeat (3) step();
    chk("rst_select", ula_select, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ready", ready_out, 1);
    rst = 1'b0;
    step();

    // Single-cycle decodes and illegal encodings
    single(2'b10, 10'b0100000_000, 1);   // SUB
    single(2'b01, 10'b0100000_101, 7);   // SRAI
    single(2'b11, 10'b1010101_010, -1);  // branch 010 illegal
    single(2'b11, 10'b0000000_110, 4);   // BLTU -> SLTU
    single(2'b00, 10'b1111111_111, 0);   // ADD, inst ignored
    single(2'b01, 10'b0000001_001, -1);  // SLLI with bad funct7
    single(2'b10, 10'b0100000_001, -1);  // R-type alt funct7, bad funct3
    single(2'b01, 10'b1111111_100, 5);   // XORI ignores funct7
    single(2'b10, 10'b0000010_000, -1);  // unknown funct7
    step();

    // Flush alongside valid_in in IDLE: dropped, no pulse
    ula_op = 2'b10; inst = 10'b0100000_000; valid_in = 1'b1; flush = 1'b1;
    step();
    valid_in = 1'b0; flush = 1'b0;
    step();
    chk("flush_idle_select", ula_select, last_sel);
    chk("flush_idle_ready", ready_out, 1);

    // DIV: busy for exactly 32 cycles, done on the last, mid-op valid ignored
    ula_op = 2'b10; inst = 10'b0000001_100; valid_in = 1'b1;
    push(K_DONE, 20, 32);
    last_sel = 20;
    step();
    valid_in = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      chk("div_busy", busy, 1);
      chk("div_ready", ready_out, 0);
      if (i == 10) begin
        ula_op = 2'b10; inst = 10'b0100000_000; valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      if (i < 32) step();
    end
    step();
    chk("div_after_busy", busy, 0);
    chk("div_after_ready", ready_out, 1);
    single(2'b10, 10'b0000000_100, 5);   // back-to-back XOR
    step();

    // MUL flushed in its 2nd busy cycle: no done, select held
    ula_op = 2'b10; inst = 10'b0000001_000; valid_in = 1'b1;
    last_sel = 16;
    step();
    valid_in = 1'b0;
    step();
    chk("mul_busy2", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("mulflush_busy", busy, 0);
    chk("mulflush_ready", ready_out, 1);
    chk("mulflush_done", done, 0);
    chk("mulflush_select", ula_select, 16);
    repeat (4) step();

    // MUL reset in its 2nd busy cycle: reset values, no done
    ula_op = 2'b10; inst = 10'b0000001_011; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    chk("mulh_busy2", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_sel = 0;
    chk("mulrst_busy", busy, 0);
    chk("mulrst_ready", ready_out, 1);
    chk("mulrst_select", ula_select, 0);
    repeat (4) step();

    // MULHU with flush in the done cycle: done still pulses
    ula_op = 2'b10; inst = 10'b0000001_011; valid_in = 1'b1;
    push(K_DONE, 19, 4);
    last_sel = 19;
    step();
    valid_in = 1'b0;
    repeat (3) step();
    chk("mulhu_done_cycle", done, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("mulhu_after_busy", busy, 0);
    step();

    // ENABLE_M = 0: MUL encoding is illegal, never busy
    ula_op = 2'b10; inst = 10'b0000001_000; valid_nom = 1'b1;
    step();
    valid_nom = 1'b0;
    chk("nom_illegal", nom_illegal, 1);
    chk("nom_busy", nom_busy, 0);
    chk("nom_sel_valid", nom_sel_valid, 0);
    step();
    chk("nom_busy_later", nom_busy, 0);
    chk("nom_illegal_width", nom_illegal, 0);

    // Sweep of the 10 base R-type ops at one per cycle
    for (int i = 0; i < 10; i++) begin
      ula_op = 2'b10; inst = sweep_inst[i]; valid_in = 1'b1;
      push(K_SEL, i, 1);
      step();
    end
    valid_in = 1'b0;

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
